// File: rtl/booth_mult_sched.sv
// Job feeder and result collector for the 8x8 radix-4 Booth multiplier.
// Optional product checker enabled by defining BOOTH_SCHED_CHECK_EN.
module booth_mult_sched #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_mplier,
  input  logic [7:0]  in_mcand,
  output logic [7:0]  mul_mplier,
  output logic [7:0]  mul_mcand,
  output logic        mul_go,
  output logic        mul_rst,
  input  logic [17:0] mul_ans,
  input  logic        mul_over,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_product,
  output logic [7:0]  out_mplier,
  output logic [7:0]  out_mcand,
  output logic        err_timeout,
  output logic        err_mismatch
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_REARM, S_ABORT} state_e;

  state_e             state_q, state_d;
  logic [15:0]        fifo_q [DEPTH];
  logic [15:0]        fifo_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic               in_ready_q, in_ready_d;
  logic [7:0]         mul_mplier_q, mul_mplier_d, mul_mcand_q, mul_mcand_d;
  logic               mul_go_q, mul_go_d, mul_rst_q, mul_rst_d;
  logic               out_valid_q, out_valid_d;
  logic [15:0]        out_product_q, out_product_d;
  logic [7:0]         out_mplier_q, out_mplier_d, out_mcand_q, out_mcand_d;
  logic               err_timeout_q, err_timeout_d;
  logic               push_c, pop_c, capture_c;
  logic               ans_unused_c;

  // Product lives in ans[16:1]; the outer bits carry nothing useful.
  assign ans_unused_c = ^{mul_ans[17], mul_ans[0]};

  assign push_c    = in_valid && in_ready_q;
  assign pop_c     = (state_q == S_IDLE) && (count_q != '0) && !out_valid_q;
  assign capture_c = (state_q == S_RUN) && mul_over;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Completion beats the watchdog when both land on the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pop_c) state_d = S_RUN;
      S_RUN: begin
        if (mul_over)                           state_d = S_REARM;
        else if (wd_q == WD_W'(TIMEOUT - 1))    state_d = S_ABORT;
      end
      S_REARM: if (!mul_over) state_d = S_IDLE;
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mul_go_d      = (state_d == S_RUN);
    mul_rst_d     = (state_d == S_ABORT);
    err_timeout_d = err_timeout_q || (state_d == S_ABORT);
  end

  always_comb begin
    fifo_d        = fifo_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    wd_d          = wd_q;
    mul_mplier_d  = mul_mplier_q;
    mul_mcand_d   = mul_mcand_q;
    out_valid_d   = out_valid_q;
    out_product_d = out_product_q;
    out_mplier_d  = out_mplier_q;
    out_mcand_d   = out_mcand_q;
    if (push_c) begin
      fifo_d[wr_ptr_q] = {in_mplier, in_mcand};
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (state_q == S_RUN) wd_d = wd_q + WD_W'(1);
    if (pop_c) begin
      {mul_mplier_d, mul_mcand_d} = fifo_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      wd_d     = '0;
    end
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (capture_c) begin
      out_valid_d   = 1'b1;
      out_product_d = mul_ans[16:1];
      out_mplier_d  = mul_mplier_q;
      out_mcand_d   = mul_mcand_q;
    end
    in_ready_d = (count_d != CNT_W'(DEPTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      wd_q          <= '0;
      in_ready_q    <= 1'b0;
      mul_mplier_q  <= '0;
      mul_mcand_q   <= '0;
      mul_go_q      <= 1'b0;
      mul_rst_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      out_product_q <= '0;
      out_mplier_q  <= '0;
      out_mcand_q   <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      fifo_q        <= fifo_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      wd_q          <= wd_d;
      in_ready_q    <= in_ready_d;
      mul_mplier_q  <= mul_mplier_d;
      mul_mcand_q   <= mul_mcand_d;
      mul_go_q      <= mul_go_d;
      mul_rst_q     <= mul_rst_d;
      out_valid_q   <= out_valid_d;
      out_product_q <= out_product_d;
      out_mplier_q  <= out_mplier_d;
      out_mcand_q   <= out_mcand_d;
      err_timeout_q <= err_timeout_d;
    end
  end

`ifdef BOOTH_SCHED_CHECK_EN
  logic               err_mismatch_q, err_mismatch_d;
  logic signed [15:0] mplier_ext_c, mcand_ext_c, exp_product_c;

  // Reference signed product of the operands currently held on the multiplier.
  always_comb begin
    mplier_ext_c   = 16'($signed(mul_mplier_q));
    mcand_ext_c    = 16'($signed(mul_mcand_q));
    exp_product_c  = 16'(mplier_ext_c * mcand_ext_c);
    err_mismatch_d = err_mismatch_q;
    if (capture_c && (mul_ans[16:1] != exp_product_c)) err_mismatch_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_mismatch_q <= 1'b0;
    else     err_mismatch_q <= err_mismatch_d;
  end

  assign err_mismatch = err_mismatch_q;
`else
  assign err_mismatch = 1'b0;
`endif

  assign in_ready    = in_ready_q;
  assign mul_mplier  = mul_mplier_q;
  assign mul_mcand   = mul_mcand_q;
  assign mul_go      = mul_go_q;
  assign mul_rst     = mul_rst_q;
  assign out_valid   = out_valid_q;
  assign out_product = out_product_q;
  assign out_mplier  = out_mplier_q;
  assign out_mcand   = out_mcand_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_booth_mult_sched.sv
// Scoreboard bench for booth_mult_sched with a behavioural Booth multiplier model.
module tb_booth_mult_sched;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_mplier = '0;
  logic [7:0]  in_mcand = '0;
  logic [7:0]  mul_mplier, mul_mcand;
  logic        mul_go, mul_rst;
  logic [17:0] mul_ans;
  logic        mul_over;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_product;
  logic [7:0]  out_mplier, out_mcand;
  logic        err_timeout, err_mismatch;

  typedef struct packed {
    logic [7:0]  mp;
    logic [7:0]  mc;
    logic [15:0] prod;
  } job_t;

  job_t sb[$];
  job_t exp_j;
  int   checks = 0;
  int   failures = 0;
  logic stall = 1'b0;
  logic wrong = 1'b0;
  logic [3:0]  mcnt;
  logic [15:0] model_p;

  booth_mult_sched #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mplier(in_mplier), .in_mcand(in_mcand),
    .mul_mplier(mul_mplier), .mul_mcand(mul_mcand),
    .mul_go(mul_go), .mul_rst(mul_rst),
    .mul_ans(mul_ans), .mul_over(mul_over),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_product(out_product), .out_mplier(out_mplier), .out_mcand(out_mcand),
    .err_timeout(err_timeout), .err_mismatch(err_mismatch)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] smul(input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] sa, sb2;
    sa  = 16'($signed(a));
    sb2 = 16'($signed(b));
    return 16'(sa * sb2);
  endfunction

  assign model_p = smul(mul_mplier, mul_mcand);

  // Multiplier model: over rises 8 cycles after go and holds until go drops.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_over <= 1'b0;
      mul_ans  <= '0;
      mcnt     <= '0;
    end else if (mul_rst || !mul_go) begin
      mul_over <= 1'b0;
      mcnt     <= '0;
    end else if (!mul_over && !stall) begin
      if (mcnt == 4'd7) begin
        mul_over <= 1'b1;
        mul_ans  <= {^model_p, (wrong ? (model_p ^ 16'h0001) : model_p), 1'b1};
      end else begin
        mcnt <= mcnt + 4'd1;
      end
    end
  end

  // Every accepted product beat is popped and compared in order.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_product got=%h required=none", out_product);
      end else begin
        exp_j = sb.pop_front();
        if ({out_product, out_mplier, out_mcand} !== {exp_j.prod, exp_j.mp, exp_j.mc}) begin
          failures++;
          $display("FAIL product got=%h/%h/%h required=%h/%h/%h", out_product, out_mplier,
                   out_mcand, exp_j.prod, exp_j.mp, exp_j.mc);
        end
      end
    end
  end

  task automatic push_job(input logic [7:0] mp, input logic [7:0] mc, input bit track,
                          input logic [15:0] prod);
    int n;
    @(negedge clk);
    in_valid = 1'b1; in_mplier = mp; in_mcand = mc;
    n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL push_wait in_ready=%b required=1", in_ready);
    end else begin
      if (track) sb.push_back('{mp: mp, mc: mc, prod: prod});
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, mul_go, mul_rst, err_timeout, err_mismatch} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b required=000000",
               {in_ready, out_valid, mul_go, mul_rst, err_timeout, err_mismatch});
    end
    checks++;
    if ({out_product, mul_mplier, mul_mcand} !== 32'h0) begin
      failures++;
      $display("FAIL reset_data got=%h required=0", {out_product, mul_mplier, mul_mcand});
    end
    #2 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || mul_go !== 1'b0) begin
      failures++;
      $display("FAIL post_reset in_ready=%b mul_go=%b required=1/0", in_ready, mul_go);
    end
  endtask

  task automatic test_basic();
    int beats;
    logic prev;
    push_job(8'd120, 8'd3, 1'b1, 16'd360);
    @(negedge clk);
    checks++;
    if (mul_go !== 1'b0) begin
      failures++; $display("FAIL go_latency_early got=%b required=0", mul_go);
    end
    @(negedge clk);
    checks++;
    if (mul_go !== 1'b1 || mul_mplier !== 8'd120 || mul_mcand !== 8'd3) begin
      failures++;
      $display("FAIL go_issue got=%b/%0d/%0d required=1/120/3", mul_go, mul_mplier, mul_mcand);
    end
    beats = 0; prev = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (out_valid && !prev) begin
        beats++;
        checks++;
        if (mul_go !== 1'b0) begin
          failures++; $display("FAIL go_after_over got=%b required=0", mul_go);
        end
      end
      prev = out_valid;
    end
    checks++;
    if (beats !== 1) begin failures++; $display("FAIL basic_beats got=%0d required=1", beats); end
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL basic_drain pending=%0d required=0", sb.size()); end
    checks++;
    if (err_mismatch !== 1'b0 || err_timeout !== 1'b0) begin
      failures++; $display("FAIL basic_errs got=%b%b required=00", err_mismatch, err_timeout);
    end
  endtask

  task automatic test_signed();
    logic [7:0] a, b;
    push_job(8'hFB, 8'h07, 1'b1, 16'hFFDD);
    push_job(8'h80, 8'h80, 1'b1, 16'h4000);
    push_job(8'h7F, 8'h80, 1'b1, 16'hC080);
    for (int i = 0; i < 4; i++) begin
      a = 8'($urandom); b = 8'($urandom);
      push_job(a, b, 1'b1, smul(a, b));
    end
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL signed_drain pending=%0d required=0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    int accepted;
    logic [7:0] a, b;
    stall = 1'b1; accepted = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      a = 8'(i * 37 + 11); b = 8'(8'hF0 + i);
      if (i == 5) begin
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%b required=0", in_ready); end
      end
      in_valid = 1'b1; in_mplier = a; in_mcand = b;
      if (in_ready) begin sb.push_back('{mp: a, mc: b, prod: smul(a, b)}); accepted++; end
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (accepted != 5 || mul_go !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_fill accepted=%0d go=%b in_ready=%b required=5/1/0", accepted, mul_go, in_ready);
    end
    stall = 1'b0;
    for (int i = 0; i < 500 && sb.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL b2b_drain pending=%0d required=0", sb.size()); end
  endtask

  task automatic test_backpressure();
    int n, hold_err;
    logic [15:0] held;
    logic [7:0] a, b;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = 8'($urandom); b = 8'($urandom);
      push_job(a, b, 1'b1, smul(a, b));
    end
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (!out_valid || sb.size() == 0) begin
      failures++; $display("FAIL bp_first got_valid=%b required=1", out_valid);
    end else begin
      held = sb[0].prod; hold_err = 0;
      for (int i = 0; i < 25; i++) begin
        @(negedge clk);
        if (mul_go !== 1'b0 || out_valid !== 1'b1 || out_product !== held) hold_err++;
      end
      checks++;
      if (hold_err != 0) begin
        failures++; $display("FAIL bp_hold bad_cycles=%0d required=0 product=%h held=%h", hold_err, out_product, held);
      end
    end
    out_ready = 1'b1;
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL bp_drain pending=%0d required=0", sb.size()); end
  endtask

  task automatic test_timeout();
    int n, go_cycles;
    logic saw_valid;
    checks++;
    if (err_timeout !== 1'b0) begin failures++; $display("FAIL to_pre got=%b required=0", err_timeout); end
    stall = 1'b1;
    push_job(8'h11, 8'h22, 1'b0, 16'h0);
    push_job(8'hF3, 8'h21, 1'b1, smul(8'hF3, 8'h21));
    @(negedge clk);
    n = 0;
    while (!mul_go && n < 50) begin @(negedge clk); n++; end
    go_cycles = 0; saw_valid = 1'b0;
    while (mul_go && go_cycles < 100) begin
      go_cycles++;
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    checks++;
    if (go_cycles != TIMEOUT || mul_rst !== 1'b1 || err_timeout !== 1'b1) begin
      failures++;
      $display("FAIL abort go_cycles=%0d mul_rst=%b err_timeout=%b required=%0d/1/1",
               go_cycles, mul_rst, err_timeout, TIMEOUT);
    end
    stall = 1'b0;
    @(negedge clk);
    checks++;
    if (mul_rst !== 1'b0) begin failures++; $display("FAIL abort_pulse got=%b required=0", mul_rst); end
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0 || err_timeout !== 1'b1 || saw_valid) begin
      failures++;
      $display("FAIL after_abort pending=%0d err_timeout=%b dropped_valid=%b required=0/1/0",
               sb.size(), err_timeout, saw_valid);
    end
  endtask

  task automatic test_reset_mid();
    int n, bad;
    stall = 1'b1;
    push_job(8'h01, 8'h02, 1'b0, 16'h0);
    push_job(8'h03, 8'h04, 1'b0, 16'h0);
    push_job(8'h05, 8'h06, 1'b0, 16'h0);
    n = 0;
    while (!mul_go && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, mul_go, mul_rst, err_timeout, err_mismatch} !== 6'b0 ||
        mul_mplier !== 8'h0 || out_product !== 16'h0) begin
      failures++;
      $display("FAIL mid_reset flags=%b mplier=%h product=%h required=0",
               {in_ready, out_valid, mul_go, mul_rst, err_timeout, err_mismatch}, mul_mplier, out_product);
    end
    @(negedge clk);
    #2 rst = 1'b0;
    stall = 1'b0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mul_go || out_valid) bad++;
    end
    checks++;
    if (bad != 0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL post_mid_reset active_cycles=%0d in_ready=%b required=0/1", bad, in_ready);
    end
  endtask

  task automatic test_mismatch();
    logic exp_flag;
`ifdef BOOTH_SCHED_CHECK_EN
    exp_flag = 1'b1;
`else
    exp_flag = 1'b0;
`endif
    wrong = 1'b1;
    push_job(8'h0C, 8'hFD, 1'b1, smul(8'h0C, 8'hFD) ^ 16'h0001);
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    wrong = 1'b0;
    checks++;
    if (sb.size() != 0 || err_mismatch !== exp_flag) begin
      failures++;
      $display("FAIL mismatch_flag got=%b pending=%0d required=%b/0", err_mismatch, sb.size(), exp_flag);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_mismatch();
    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
